router_reg: RTL and testbench
=============================

# router_reg

Datapath register stage of the 1x3 packet router. It sits directly downstream of `router_fsm` and consumes that block's state-decode strobes. It latches the header byte, forwards header, payload and parity bytes onto `dout` toward the output FIFOs, and holds one byte while a FIFO is full. It also computes running parity and returns `parity_done`, `low_pkt_valid` and `err`; the first two feed back into `router_fsm`.

## Interface
- `WIDTH`, default 8: data byte width.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pkt_valid`  in  1  source byte valid; falls on the cycle the parity byte is on `data_in`.
- `data_in`  in  WIDTH  packet byte stream; header is [7:2] payload length and [1:0] destination address.
- `fifo_full`  in  1  selected FIFO full.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`  in  1 each  one-hot state strobes from `router_fsm`.
- `dout`  out  WIDTH  byte presented to FIFOs.
- `parity_done`  out  1  parity byte captured for the current packet.
- `low_pkt_valid`  out  1  `pkt_valid` seen low while loading data.
- `err`  out  1  parity mismatch on the last packet.

## Operation
- Internal registers:
  - `hdr`: header.
  - `hold`: full-hold byte.
  - `hold_pl`: 1 means `hold` is payload, 0 means it is the parity byte.
  - `int_par`: running XOR.
  - `pkt_par`: received parity.
  - `chk`: error already evaluated.
- Header capture: `detect_add && pkt_valid && data_in[1:0]!=2'b11` → `hdr<=data_in`. Address 3 is never captured.
- `dout` update, priority order:
  - `lfd_state` → `hdr`.
  - `ld_state && !fifo_full` → `data_in`.
  - `ld_state && fifo_full` → `dout` holds; `hold<=data_in`; `hold_pl<=pkt_valid`.
  - `laf_state` → `hold`.
  - Otherwise hold.
- Running parity:
  - `detect_add` → `int_par<=0`.
  - `lfd_state` → `int_par^=hdr`.
  - `ld_state && pkt_valid && !fifo_full` → `int_par^=data_in`.
  - `laf_state && hold_pl` → `int_par^=hold`.
  - Every header/payload byte is XORed exactly once; the parity byte is never XORed.
- Packet parity and `parity_done`:
  - `ld_state && !pkt_valid && !fifo_full` → `pkt_par<=data_in`, `parity_done<=1`.
  - `laf_state && !hold_pl && !parity_done` → `pkt_par<=hold`, `parity_done<=1`.
  - `detect_add` → `parity_done<=0`.
- `low_pkt_valid`:
  - Set by `ld_state && !pkt_valid`.
  - Cleared by `rst_int_reg` or `detect_add`; clear wins on a simultaneous set and clear.
- Error:
  - When `parity_done && !chk`: `err<=(int_par!=pkt_par)` and `chk<=1`.
  - `detect_add` clears `chk`; `err` is NOT cleared by `detect_add`.
  - `err` holds until the next packet's evaluation or `reset`.
- `full_state` is informational only: `dout`, `hold` and parity are frozen while it is asserted.

## Timing
- Reset values: `dout`=0, `parity_done`=0, `low_pkt_valid`=0, `err`=0. Internal registers also reset to 0.
- Reset mid-packet clears everything in the same edge. Strobes arriving after reset are treated as fresh.
- `dout` latency is 1 cycle:
  - Header appears on `dout` the cycle after `lfd_state`.
  - Each payload byte appears the cycle after its `ld_state` cycle.
- `parity_done` rises 1 cycle after the parity capture cycle.
- `err` is valid 1 cycle after `parity_done` rises, i.e. 2 cycles after parity capture.
- Full hold is a single-entry buffer. `router_fsm` guarantees at most one `ld_state && fifo_full` cycle per full episode; a second capture overwrites `hold`.
- Only one strobe is active per cycle. If several are asserted, the `dout` priority order above applies.

## Test plan
- Reset: drive `reset`=1 for 2 cycles with random strobes → all outputs 0.
- Good packet: header 0x0D, payload 0x11, 0x22, 0x33, parity 0x0D, `fifo_full`=0 → `dout` sequence 0x0D, 0x11, 0x22, 0x33, 0x0D; `parity_done`=1; `low_pkt_valid`=1; `err`=0.
- Bad parity: same packet with parity 0x0E → `err`=1 two cycles after capture; `err` stays 1 through the next `detect_add`; next good packet → `err`=0.
- Full mid-payload: `fifo_full`=1 on the 0x22 `ld_state` cycle, then `full_state`×3, then `laf_state` → `dout` holds 0x11, then shows 0x22; final `err`=0.
- Full on parity byte: `fifo_full`=1 when parity 0x0D arrives, then `laf_state` → `parity_done` rises the cycle after `laf_state`; `err`=0.
- Address 3 and mid-packet reset: header 0x07 with `detect_add` → `hdr` unchanged; `reset` during payload → outputs 0 next edge.

Source files
------------

// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 packet router: header latch, byte forwarding,
// single-entry full-hold buffer, running parity and parity error flag.
module router_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pkt_valid,
   input  logic [WIDTH-1:0] data_in,
   input  logic             fifo_full,
   input  logic             detect_add,
   input  logic             lfd_state,
   input  logic             ld_state,
   input  logic             laf_state,
   input  logic             full_state,
   input  logic             rst_int_reg,
   output logic [WIDTH-1:0] dout,
   output logic             parity_done,
   output logic             low_pkt_valid,
   output logic             err
);

   logic [WIDTH-1:0] hdr_r, hold_r, int_par_r, pkt_par_r, dout_r;
   logic             hold_pl_r, chk_r, parity_done_r, low_pkt_valid_r, err_r;

   logic [WIDTH-1:0] hdr_s, hold_s, int_par_s, pkt_par_s, dout_s;
   logic             hold_pl_s, chk_s, parity_done_s, low_pkt_valid_s, err_s;
   logic             full_unused_s;

   function automatic logic [WIDTH-1:0] par_acc(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] b);
      return acc ^ b;
   endfunction

   assign dout          = dout_r;
   assign parity_done   = parity_done_r;
   assign low_pkt_valid = low_pkt_valid_r;
   assign err           = err_r;

   // Next-state computation for every datapath register.
   always_comb begin
      hdr_s           = hdr_r;
      hold_s          = hold_r;
      hold_pl_s       = hold_pl_r;
      int_par_s       = int_par_r;
      pkt_par_s       = pkt_par_r;
      dout_s          = dout_r;
      chk_s           = chk_r;
      parity_done_s   = parity_done_r;
      low_pkt_valid_s = low_pkt_valid_r;
      err_s           = err_r;
      // full_state only marks a wait; nothing moves while it is asserted.
      full_unused_s   = full_state;

      // Address 3 is not a valid destination, so its header is never latched.
      if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
         hdr_s = data_in;
      end else begin
         hdr_s = hdr_r;
      end

      if (lfd_state) begin
         dout_s = hdr_r;
      end else if (ld_state && !fifo_full) begin
         dout_s = data_in;
      end else if (ld_state && fifo_full) begin
         hold_s    = data_in;
         hold_pl_s = pkt_valid;
      end else if (laf_state) begin
         dout_s = hold_r;
      end else begin
         dout_s = dout_r;
      end

      // A held payload byte is folded in when it is released, not when captured.
      if (detect_add) begin
         int_par_s = {WIDTH{1'b0}};
      end else if (lfd_state) begin
         int_par_s = par_acc(int_par_r, hdr_r);
      end else if (ld_state && pkt_valid && !fifo_full) begin
         int_par_s = par_acc(int_par_r, data_in);
      end else if (laf_state && hold_pl_r) begin
         int_par_s = par_acc(int_par_r, hold_r);
      end else begin
         int_par_s = int_par_r;
      end

      if (detect_add) begin
         parity_done_s = 1'b0;
      end else if (ld_state && !pkt_valid && !fifo_full) begin
         pkt_par_s     = data_in;
         parity_done_s = 1'b1;
      end else if (laf_state && !hold_pl_r && !parity_done_r) begin
         pkt_par_s     = hold_r;
         parity_done_s = 1'b1;
      end else begin
         parity_done_s = parity_done_r;
      end

      if (rst_int_reg || detect_add) begin
         low_pkt_valid_s = 1'b0;
      end else if (ld_state && !pkt_valid) begin
         low_pkt_valid_s = 1'b1;
      end else begin
         low_pkt_valid_s = low_pkt_valid_r;
      end

      // err survives detect_add so the previous packet's result stays visible.
      if (detect_add) begin
         chk_s = 1'b0;
      end else if (parity_done_r && !chk_r) begin
         err_s = (int_par_r != pkt_par_r);
         chk_s = 1'b1;
      end else begin
         chk_s = chk_r;
      end
   end

   // Register bank with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         hdr_r           <= {WIDTH{1'b0}};
         hold_r          <= {WIDTH{1'b0}};
         hold_pl_r       <= 1'b0;
         int_par_r       <= {WIDTH{1'b0}};
         pkt_par_r       <= {WIDTH{1'b0}};
         dout_r          <= {WIDTH{1'b0}};
         chk_r           <= 1'b0;
         parity_done_r   <= 1'b0;
         low_pkt_valid_r <= 1'b0;
         err_r           <= 1'b0;
      end else begin
         hdr_r           <= hdr_s;
         hold_r          <= hold_s;
         hold_pl_r       <= hold_pl_s;
         int_par_r       <= int_par_s;
         pkt_par_r       <= pkt_par_s;
         dout_r          <= dout_s;
         chk_r           <= chk_s;
         parity_done_r   <= parity_done_s;
         low_pkt_valid_r <= low_pkt_valid_s;
         err_r           <= err_s;
      end
   end

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: hand-computed dout/parity/err expectations.
module tb_router_reg;

   localparam int S_NONE = 0;
   localparam int S_DA   = 1;
   localparam int S_LFD  = 2;
   localparam int S_LD   = 3;
   localparam int S_LAF  = 4;
   localparam int S_FULL = 5;
   localparam int S_RIR  = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       fifo_full;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [7:0] dout;
   logic       parity_done, low_pkt_valid, err;

   int checks = 0;
   int errors = 0;

   router_reg #(.WIDTH(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .pkt_valid    (pkt_valid),
      .data_in      (data_in),
      .fifo_full    (fifo_full),
      .detect_add   (detect_add),
      .lfd_state    (lfd_state),
      .ld_state     (ld_state),
      .laf_state    (laf_state),
      .full_state   (full_state),
      .rst_int_reg  (rst_int_reg),
      .dout         (dout),
      .parity_done  (parity_done),
      .low_pkt_valid(low_pkt_valid),
      .err          (err)
   );

   always #5 clock = ~clock;

   task automatic tick(input int s, input logic pv, input logic [7:0] d, input logic ff);
      detect_add  = (s == S_DA);
      lfd_state   = (s == S_LFD);
      ld_state    = (s == S_LD);
      laf_state   = (s == S_LAF);
      full_state  = (s == S_FULL);
      rst_int_reg = (s == S_RIR);
      pkt_valid   = pv;
      data_in     = d;
      fifo_full   = ff;
      @(posedge clock);
      #1;
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Header 0x0D, payload 11/22/33, given parity byte, no FIFO full.
   task automatic send_plain(input logic [7:0] par);
      tick(S_DA,  1'b1, 8'h0D, 1'b0);
      tick(S_LFD, 1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h22, 1'b0);
      tick(S_LD,  1'b1, 8'h33, 1'b0);
      tick(S_LD,  1'b0, par,   1'b0);
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         detect_add  = 1'($urandom);
         lfd_state   = 1'($urandom);
         ld_state    = 1'($urandom);
         laf_state   = 1'($urandom);
         full_state  = 1'($urandom);
         rst_int_reg = 1'($urandom);
         pkt_valid   = 1'($urandom);
         data_in     = 8'($urandom);
         fifo_full   = 1'($urandom);
         @(posedge clock);
         #1;
      end
      check8("rst_dout", dout, 8'h00);
      check1("rst_pd",   parity_done, 1'b0);
      check1("rst_lpv",  low_pkt_valid, 1'b0);
      check1("rst_err",  err, 1'b0);
      reset = 1'b0;

      // Good packet, checking each forwarded byte.
      tick(S_DA,  1'b1, 8'h0D, 1'b0);
      check1("good_pd_clr", parity_done, 1'b0);
      tick(S_LFD, 1'b1, 8'h11, 1'b0);
      check8("good_hdr", dout, 8'h0D);
      tick(S_LD,  1'b1, 8'h11, 1'b0);
      check8("good_b1", dout, 8'h11);
      tick(S_LD,  1'b1, 8'h22, 1'b0);
      check8("good_b2", dout, 8'h22);
      tick(S_LD,  1'b1, 8'h33, 1'b0);
      check8("good_b3", dout, 8'h33);
      check1("good_pd_early", parity_done, 1'b0);
      tick(S_LD,  1'b0, 8'h0D, 1'b0);
      check8("good_par", dout, 8'h0D);
      check1("good_pd", parity_done, 1'b1);
      check1("good_lpv", low_pkt_valid, 1'b1);
      tick(S_NONE, 1'b0, 8'h00, 1'b0);
      check1("good_err", err, 1'b0);
      tick(S_RIR, 1'b0, 8'h00, 1'b0);
      check1("good_lpv_clr", low_pkt_valid, 1'b0);

      // Bad parity, err persists across next detect_add, cleared by good packet.
      send_plain(8'h0E);
      check1("bad_pd", parity_done, 1'b1);
      check1("bad_err_wait", err, 1'b0);
      tick(S_NONE, 1'b0, 8'h00, 1'b0);
      check1("bad_err", err, 1'b1);
      tick(S_DA, 1'b1, 8'h0D, 1'b0);
      check1("bad_err_hold_da", err, 1'b1);
      check1("bad_lpv_da", low_pkt_valid, 1'b0);
      tick(S_LFD, 1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h22, 1'b0);
      tick(S_LD,  1'b1, 8'h33, 1'b0);
      tick(S_LD,  1'b0, 8'h0D, 1'b0);
      check1("next_err_hold", err, 1'b1);
      tick(S_NONE, 1'b0, 8'h00, 1'b0);
      check1("next_err_clr", err, 1'b0);

      // FIFO full on the 0x22 payload byte.
      tick(S_DA,  1'b1, 8'h0D, 1'b0);
      tick(S_LFD, 1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h22, 1'b1);
      check8("mid_full_hold", dout, 8'h11);
      for (int i = 0; i < 3; i++) begin
         tick(S_FULL, 1'b1, 8'h33, 1'b1);
      end
      check8("mid_full_frozen", dout, 8'h11);
      tick(S_LAF, 1'b1, 8'h33, 1'b0);
      check8("mid_laf", dout, 8'h22);
      tick(S_LD,  1'b1, 8'h33, 1'b0);
      check8("mid_b3", dout, 8'h33);
      tick(S_LD,  1'b0, 8'h0D, 1'b0);
      check1("mid_pd", parity_done, 1'b1);
      tick(S_NONE, 1'b0, 8'h00, 1'b0);
      check1("mid_err", err, 1'b0);

      // FIFO full on the parity byte.
      tick(S_DA,  1'b1, 8'h0D, 1'b0);
      tick(S_LFD, 1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h11, 1'b0);
      tick(S_LD,  1'b1, 8'h22, 1'b0);
      tick(S_LD,  1'b1, 8'h33, 1'b0);
      tick(S_LD,  1'b0, 8'h0D, 1'b1);
      check1("pfull_pd_none", parity_done, 1'b0);
      check8("pfull_dout_hold", dout, 8'h33);
      tick(S_FULL, 1'b0, 8'h00, 1'b1);
      check1("pfull_pd_frozen", parity_done, 1'b0);
      tick(S_LAF, 1'b0, 8'h00, 1'b0);
      check1("pfull_pd", parity_done, 1'b1);
      check8("pfull_dout", dout, 8'h0D);
      tick(S_NONE, 1'b0, 8'h00, 1'b0);
      check1("pfull_err", err, 1'b0);

      // Leave err set, then address-3 header and a mid-packet reset.
      send_plain(8'h0E);
      tick(S_NONE, 1'b0, 8'h00, 1'b0);
      check1("a3_err_set", err, 1'b1);
      tick(S_DA,  1'b1, 8'h07, 1'b0);
      tick(S_LFD, 1'b1, 8'h11, 1'b0);
      check8("a3_hdr_kept", dout, 8'h0D);
      tick(S_LD,  1'b1, 8'h11, 1'b0);
      check8("a3_b1", dout, 8'h11);
      reset = 1'b1;
      tick(S_LD,  1'b0, 8'h22, 1'b0);
      check8("mrst_dout", dout, 8'h00);
      check1("mrst_pd",   parity_done, 1'b0);
      check1("mrst_lpv",  low_pkt_valid, 1'b0);
      check1("mrst_err",  err, 1'b0);
      reset = 1'b0;
      tick(S_LFD, 1'b1, 8'h00, 1'b0);
      check8("mrst_hdr_zero", dout, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
